// File: rtl/bop_delay_queue.sv
// Timestamped delay queue for the best-offset prefetcher: entries age DELAY cycles before being offered.
// Build option: define BOP_DQ_OVERWRITE_EN to evict the head on a push into a full queue (default: reject).
module bop_delay_queue #(
  parameter int WIDTH     = 12,
  parameter int DEPTH     = 15,
  parameter int DELAY     = 60,
  parameter int TIME_BITS = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cq_enq,
  input  logic [WIDTH-1:0]           cq_in,
  input  logic                       cq_deq,
  output logic [WIDTH-1:0]           cq_out,
  output logic                       cq_empty,
  output logic                       cq_full,
  output logic                       cq_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [15:0]                drop_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [TIME_BITS-1:0] DELAY_T = TIME_BITS'(DELAY);
  localparam logic [PTR_W-1:0]     LAST_P  = PTR_W'(DEPTH-1);

  logic [WIDTH-1:0]     data_q [DEPTH];
  logic [TIME_BITS-1:0] ts_q   [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [DEPTH-1:0]     ripe_q, ripe_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [TIME_BITS-1:0] now_q, now_d;
  logic [15:0]          drop_q, drop_d;

  logic                 pop, push, evict, drop, adv_head;
  logic [TIME_BITS-1:0] head_age;

  function automatic logic [TIME_BITS-1:0] age_of(input logic [TIME_BITS-1:0] now,
                                                  input logic [TIME_BITS-1:0] ts);
    return now - ts;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Head status is combinational from registered state so the consumer can pop on the same edge.
  always_comb begin
    head_age = age_of(now_q, ts_q[head_q]);
    cq_empty = (occ_q == '0);
    cq_full  = (occ_q == OCC_W'(DEPTH));
    cq_ready = !cq_empty && (ripe_q[head_q] || (head_age >= DELAY_T));
    cq_out   = cq_empty ? '0 : data_q[head_q];
  end

  assign occupancy_o  = occ_q;
  assign drop_count_o = drop_q;

  always_comb begin
    pop  = cq_deq && cq_ready;
    drop = cq_enq && cq_full && !pop;
`ifdef BOP_DQ_OVERWRITE_EN
    push  = cq_enq;
    evict = drop;
`else
    push  = cq_enq && !drop;
    evict = 1'b0;
`endif
    adv_head = pop || evict;
  end

  always_comb begin
    now_d  = now_q + TIME_BITS'(1);
    head_d = adv_head ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
    drop_d = drop ? sat_inc(drop_q) : drop_q;
    case ({push, adv_head})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    vld_d  = vld_q;
    ripe_d = ripe_q;
    // Latch maturity the first cycle it is reached so a later wrap of now cannot undo it.
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (age_of(now_q, ts_q[i]) >= DELAY_T)) ripe_d[i] = 1'b1;
    end
    if (adv_head) begin
      vld_d[head_q]  = 1'b0;
      ripe_d[head_q] = 1'b0;
    end
    // When full, tail equals head, so the push must override the head clear above.
    if (push) begin
      vld_d[tail_q]  = 1'b1;
      ripe_d[tail_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      ripe_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      now_q  <= '0;
      drop_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ripe_q <= ripe_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      now_q  <= now_d;
      drop_q <= drop_d;
    end
  end

  // Payload and timestamp storage carry no reset; validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q] <= cq_in;
      ts_q[tail_q]   <= now_q;
    end
  end

endmodule

// File: tb/tb_bop_delay_queue.sv
// Directed bench for bop_delay_queue; expectations follow BOP_DQ_OVERWRITE_EN when defined.
module tb_bop_delay_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        cq_enq, cq_deq;
  logic [11:0] cq_in, cq_out;
  logic        cq_empty, cq_full, cq_ready;
  logic [3:0]  occ;
  logic [15:0] drop;

  logic        s_enq;
  logic [11:0] s_in, s_out;
  logic        s_empty, s_full, s_ready;
  logic [3:0]  s_occ;
  logic [15:0] s_drop;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bop_delay_queue #(.WIDTH(12), .DEPTH(15), .DELAY(60), .TIME_BITS(12)) u_dut (
    .clk(clk), .rst(rst), .cq_enq(cq_enq), .cq_in(cq_in), .cq_deq(cq_deq),
    .cq_out(cq_out), .cq_empty(cq_empty), .cq_full(cq_full), .cq_ready(cq_ready),
    .occupancy_o(occ), .drop_count_o(drop)
  );

  // Short-delay instance for continuous streaming with cq_deq tied high.
  bop_delay_queue #(.WIDTH(12), .DEPTH(15), .DELAY(10), .TIME_BITS(12)) u_dut_s (
    .clk(clk), .rst(rst), .cq_enq(s_enq), .cq_in(s_in), .cq_deq(1'b1),
    .cq_out(s_out), .cq_empty(s_empty), .cq_full(s_full), .cq_ready(s_ready),
    .occupancy_o(s_occ), .drop_count_o(s_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int n = 0;
    while (!cq_ready && n < bound) begin
      step();
      n++;
    end
    chk(tag, cq_ready, 1);
  endtask

  // Push one value with cq_deq=1, confirm it becomes ready exactly 60 cycles after the push edge, then pop it.
  task automatic check_mature(input string tag, input logic [11:0] val);
    int early = 0;
    cq_deq = 1'b1;
    cq_enq = 1'b1;
    cq_in  = val;
    step();
    cq_enq = 1'b0;
    for (int i = 0; i < 59; i++) begin
      if (cq_ready !== 1'b0) early++;
      step();
    end
    chk({tag, "_early_ready"}, early, 0);
    chk({tag, "_ready"}, cq_ready, 1);
    chk({tag, "_out"}, cq_out, val);
    step();
    chk({tag, "_empty_after_pop"}, cq_empty, 1);
    cq_deq = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [11:0] val);
    wait_ready({tag, "_ready"}, 100);
    chk({tag, "_out"}, cq_out, val);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] base;
    int          bad;
    logic        exp_rdy;

    rst = 1'b1; cq_enq = 1'b0; cq_deq = 1'b0; cq_in = '0; s_enq = 1'b0; s_in = '0;
    #12;
    chk("rst_empty", cq_empty, 1);
    chk("rst_full", cq_full, 0);
    chk("rst_ready", cq_ready, 0);
    chk("rst_out", cq_out, 0);
    chk("rst_occ", occ, 0);
    chk("rst_drop", drop, 0);
    rst = 1'b0;

    // now counts 0..4 over five idle edges so the push samples now=5
    for (int i = 0; i < 5; i++) step();
    check_mature("t1", 12'h0AB);

    for (int i = 0; i < 16; i++) begin
      cq_enq = 1'b1;
      cq_in  = 12'(12'h101 + i);
      step();
    end
    cq_enq = 1'b0;
    chk("t2_occ", occ, 15);
    chk("t2_full", cq_full, 1);
    chk("t2_drop", drop, 1);
`ifdef BOP_DQ_OVERWRITE_EN
    chk("t2_head", cq_out, 12'h102);
    base = 12'h103;
`else
    chk("t2_head", cq_out, 12'h101);
    base = 12'h102;
`endif

    wait_ready("t3_head_mature", 100);
    cq_enq = 1'b1; cq_in = 12'h1AA; cq_deq = 1'b1;
    step();
    cq_enq = 1'b0;
    chk("t3_occ", occ, 15);
    chk("t3_drop", drop, 1);
    chk("t3_full", cq_full, 1);
    for (int i = 0; i < 14; i++) pop_expect("t3_drain", 12'(base + i));
    pop_expect("t3_tail", 12'h1AA);
    chk("t3_empty", cq_empty, 1);
    cq_deq = 1'b0;

    cq_enq = 1'b1; cq_in = 12'h3C3;
    step();
    cq_enq = 1'b0;
    wait_ready("t4_mature", 80);
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      if (cq_ready !== 1'b1 || cq_out !== 12'h3C3) bad++;
      step();
    end
    chk("t4_ready_held", bad, 0);
    chk("t4_out", cq_out, 12'h3C3);
    cq_deq = 1'b1;
    step();
    chk("t4_empty", cq_empty, 1);
    cq_deq = 1'b0;

    for (int i = 0; i < 7; i++) begin
      cq_enq = 1'b1;
      cq_in  = 12'(12'h400 + i);
      step();
    end
    cq_enq = 1'b0;
    chk("t5_occ_before", occ, 7);
    chk("t5_drop_before", drop, 1);
    #3 rst = 1'b1;
    #1;
    chk("t5_empty", cq_empty, 1);
    chk("t5_ready", cq_ready, 0);
    chk("t5_out", cq_out, 0);
    chk("t5_occ", occ, 0);
    chk("t5_drop", drop, 0);
    #2 rst = 1'b0;
    check_mature("t5", 12'h4AA);

    // Stream: entry i pushed on step i+1, ready after step i+10, popped on step i+11.
    for (int s = 1; s <= 30; s++) begin
      s_enq = (s <= 20);
      s_in  = 12'(12'h200 + s - 1);
      step();
      exp_rdy = (s >= 10 && s <= 29);
      chk("t6_ready", s_ready, exp_rdy);
      if (exp_rdy) chk("t6_out", s_out, 12'(12'h200 + s - 10));
    end
    s_enq = 1'b0;
    chk("t6_empty", s_empty, 1);
    chk("t6_occ", s_occ, 0);
    chk("t6_drop", s_drop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bop_delay_queue.md
# bop_delay_queue

Timestamped delay queue for the best-offset prefetcher. It holds each prefetch base address for a fixed number of cycles, then presents it for insertion into the left bank of the recent-requests table. The prefetcher pushes an address on every issued prefetch and pops whenever an entry has matured; this block consumes the prefetcher's `cq_enq`/`cq_in` and feeds back `cq_out`/`cq_ready`/`cq_empty`/`cq_full`.

## Interface
Parameters:
- `WIDTH`, 12: entry data width; matches the prefetcher tag width.
- `DEPTH`, 15: number of entries; need not be a power of two; must be ≥ 2.
- `DELAY`, 60: cycles an entry must age before it becomes ready; 1 ≤ `DELAY` < 2^`TIME_BITS`.
- `TIME_BITS`, 12: width of the free-running time counter and of the stored timestamps.

Ports:
- `clk` in 1: clock; all state changes on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `cq_enq` in 1: push `cq_in` this cycle.
- `cq_in` in `WIDTH`: data to push.
- `cq_deq` in 1: pop request; takes effect only when `cq_ready`=1.
- `cq_out` out `WIDTH`: head data; 0 when empty.
- `cq_empty` out 1: occupancy == 0.
- `cq_full` out 1: occupancy == `DEPTH`.
- `cq_ready` out 1: head is valid and matured.
- `occupancy_o` out $clog2(`DEPTH`+1): current entry count.
- `drop_count_o` out 16: saturating count of discarded pushes or evictions.

## Operation
- `now`: a `TIME_BITS` counter that increments every cycle and wraps.
- Each entry stores `data`, `ts`, and a sticky `ripe` bit.
- `age(e)` = (`now` − `e.ts`) mod 2^`TIME_BITS`.
- Push: writes `{cq_in, ts=now, ripe=0}` at `tail`, then `tail` advances.
- Pointers `head`/`tail` wrap from `DEPTH`−1 to 0.
- `cq_ready` (combinational) = occupancy ≠ 0 and (`ripe[head]` or `age(head)` ≥ `DELAY`).
- Ripe update: each cycle, every valid entry with `age` ≥ `DELAY` sets `ripe`. Because it is set the first cycle maturity is reached, later wrap of `now` cannot un-mature an entry, even when the head is stalled for more than 2^`TIME_BITS` cycles.
- Pop: on an edge with `cq_deq`=1 and `cq_ready`=1, `head` advances and that entry's valid and `ripe` bits clear.
- `cq_deq` with `cq_ready`=0 is ignored. `cq_deq` tied high is legal.
- No bypass: a push into an empty queue is not visible as ready for `DELAY` cycles.
- Push and pop on the same edge are both honoured; occupancy is unchanged.
- Push when full, with a pop on the same edge: no drop; normal push+pop.
- Push when full, without a pop: handled per Configuration; `drop_count_o` increments and saturates at 0xFFFF.
- Reset values: all valid and `ripe` bits, `head`, `tail`, occupancy, `now` and `drop_count_o` are 0. Therefore `cq_out`=0, `cq_empty`=1, `cq_full`=0, `cq_ready`=0. Storage data is not reset.
- Reset mid-operation: all entries are lost immediately, asynchronously. The first push after deassertion sees `now`=0.

## Timing
- Push latency: an entry pushed on edge k, with `now`=N sampled at that edge, has `age`=1 in cycle k+1.
- `cq_ready` for that entry (if it is head) rises in cycle k+`DELAY`, i.e. `DELAY` cycles after the push edge.
- `cq_out` and `cq_ready` are combinational from registered state. They are valid the same cycle, and the consumer samples them before the pop edge.
- `cq_full`, `cq_empty` and `occupancy_o` reflect state after the last edge.
- Throughput: one push and one pop per cycle.

## Configuration
- `BOP_DQ_OVERWRITE_EN` defined:
  - Push when full without a pop evicts the head: `head` advances, the new entry is written at `tail`, and occupancy stays `DEPTH`.
  - The evicted entry is discarded regardless of its ripeness; `drop_count_o`+1.
- Not defined:
  - Push when full without a pop is rejected; the queue is unchanged; `drop_count_o`+1.

## Test plan
- Reset, then push 0x0AB at `now`=5 with `cq_deq`=1: `cq_ready` stays low 59 cycles and goes high in cycle 65 with `cq_out`=0x0AB; the pop on that edge gives `cq_empty`=1.
- Push 16 entries on consecutive cycles into `DEPTH`=15 with `cq_deq`=0:
  - With macro: occupancy 15, head = second pushed value, `drop_count_o`=1.
  - Without macro: head = first pushed value, tail content = 15th value, `drop_count_o`=1.
- Full queue with matured head, push and `cq_deq`=1 on the same edge: occupancy stays 15, `drop_count_o` unchanged, and the new tail holds the pushed value.
- Push one entry and hold `cq_deq`=0 for 5000 cycles (past the `now` wrap): `cq_ready` stays 1 throughout, and then pops with the correct data.
- Assert `rst` asynchronously, mid-cycle, with 7 entries: outputs immediately read `cq_empty`=1, `cq_ready`=0, `cq_out`=0, `occupancy_o`=0. After release, a push matures after exactly `DELAY` cycles.
- Push 20 entries with `cq_deq`=1 held continuously at one push per cycle: pops occur one per cycle, in order, each `DELAY` cycles after its push. `head` wraps from 14 to 0 without loss, and `drop_count_o`=0.
